// File: rtl/ps2_kbd_rx.sv
// Purpose : PS/2 keyboard receiver; deframes device-to-host frames and emits one scan code per key event.
// Latency : rx_valid / parity_err / frame_err rise 1 CLK after the filtered falling edge that samples the stop bit.
// Backpr. : none; the PS/2 device cannot be stalled, so each result is a single-cycle pulse that must be consumed.
//
// Ports
//   CLK          system clock (only clock)
//   RST          synchronous reset, active low
//   ps2_clk      PS/2 clock pin, asynchronous to CLK
//   ps2_data     PS/2 data pin, asynchronous to CLK
//   rx_data      last accepted scan code, held until the next accept
//   rx_valid     1-cycle pulse: rx_data / rx_break / rx_extended are new
//   rx_break     accepted code was preceded by an F0 prefix (key release)
//   rx_extended  accepted code was preceded by an E0 prefix
//   parity_err   1-cycle pulse: frame dropped because odd parity failed
//   frame_err    1-cycle pulse: frame dropped because of a bad stop bit or an inter-bit timeout
module ps2_kbd_rx #(
    parameter int FILTER_LEN  = 8,
    parameter int TIMEOUT_CYC = 200000
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_break,
    output logic       rx_extended,
    output logic       parity_err,
    output logic       frame_err
);

    localparam int FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    localparam logic [7:0] CODE_BREAK = 8'hF0;
    localparam logic [7:0] CODE_EXT   = 8'hE0;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Input conditioning
    // ------------------------------------------------------------------
    logic          clk_s1, clk_s2;
    logic          dat_s1, dat_s2;
    logic          filt_clk;
    logic [FW-1:0] filt_cnt;
    logic          fall;

    // Synchronisers reset to the idle-high line level so that leaving
    // reset never fabricates an edge.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            clk_s1 <= 1'b1;
            clk_s2 <= 1'b1;
            dat_s1 <= 1'b1;
            dat_s2 <= 1'b1;
        end else begin
            clk_s1 <= ps2_clk;
            clk_s2 <= clk_s1;
            dat_s1 <= ps2_data;
            dat_s2 <= dat_s1;
        end
    end

    // The filtered clock only follows the synced pin after it has
    // disagreed for FILTER_LEN consecutive cycles; any agreement restarts
    // the count, so short glitches are swallowed. fall is registered in
    // the same cycle filt_clk drops, giving a clean 1-cycle strobe.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            filt_clk <= 1'b1;
            filt_cnt <= '0;
            fall     <= 1'b0;
        end else begin
            fall <= 1'b0;
            if (clk_s2 != filt_clk) begin
                if (filt_cnt == FW'(FILTER_LEN - 1)) begin
                    filt_clk <= clk_s2;
                    filt_cnt <= '0;
                    fall     <= filt_clk & ~clk_s2;
                end else begin
                    filt_cnt <= filt_cnt + 1'b1;
                end
            end else begin
                filt_cnt <= '0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Frame FSM, prefix tracking and registered outputs
    // ------------------------------------------------------------------
    state_t        state;
    logic [2:0]    bit_cnt;
    logic [7:0]    shreg;
    logic          par_bit;
    logic [TW-1:0] tmo_cnt;
    logic          break_flag;
    logic          ext_flag;

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state       <= IDLE;
            bit_cnt     <= '0;
            shreg       <= '0;
            par_bit     <= 1'b0;
            tmo_cnt     <= '0;
            break_flag  <= 1'b0;
            ext_flag    <= 1'b0;
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            rx_break    <= 1'b0;
            rx_extended <= 1'b0;
            parity_err  <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            rx_valid   <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;

            // A falling edge always takes priority over the timeout, even
            // when both land in the same cycle.
            if (fall) begin
                tmo_cnt <= '0;
                case (state)
                    IDLE: begin
                        // A high start bit is line noise; ignore it quietly.
                        if (!dat_s2) begin
                            state   <= DATA;
                            bit_cnt <= '0;
                        end
                    end
                    DATA: begin
                        // LSB arrives first, so shift in from the top.
                        shreg   <= {dat_s2, shreg[7:1]};
                        bit_cnt <= bit_cnt + 1'b1;
                        if (bit_cnt == 3'd7) begin
                            state <= PARITY;
                        end
                    end
                    PARITY: begin
                        par_bit <= dat_s2;
                        state   <= STOP;
                    end
                    STOP: begin
                        state <= IDLE;
                        if ((^shreg ^ par_bit) != 1'b1) begin
                            parity_err <= 1'b1;
                            break_flag <= 1'b0;
                            ext_flag   <= 1'b0;
                        end else if (!dat_s2) begin
                            frame_err  <= 1'b1;
                            break_flag <= 1'b0;
                            ext_flag   <= 1'b0;
                        end else if (shreg == CODE_BREAK) begin
                            break_flag <= 1'b1;
                        end else if (shreg == CODE_EXT) begin
                            ext_flag <= 1'b1;
                        end else begin
                            rx_data     <= shreg;
                            rx_break    <= break_flag;
                            rx_extended <= ext_flag;
                            rx_valid    <= 1'b1;
                            break_flag  <= 1'b0;
                            ext_flag    <= 1'b0;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end else if (state == IDLE) begin
                tmo_cnt <= '0;
            end else if (tmo_cnt == TW'(TIMEOUT_CYC - 1)) begin
                // Device stopped clocking mid-frame: drop it and resync.
                state      <= IDLE;
                tmo_cnt    <= '0;
                frame_err  <= 1'b1;
                break_flag <= 1'b0;
                ext_flag   <= 1'b0;
            end else begin
                tmo_cnt <= tmo_cnt + 1'b1;
            end
        end
    end

endmodule
